// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_e      : clear sequencer states
//   rf_pick_t       : result of the write-port priority merge
//   rf_merge_write  : higher-index-wins selection over up to two write ports
package regfile_pkg;

  localparam int RF_DEFAULT_DATA_W = 32;
  localparam int RF_DEFAULT_DEPTH  = 32;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  typedef struct packed {
    logic hit;  // at least one port matched
    logic idx;  // winning port index (valid when hit)
  } rf_pick_t;

  // match[w] = write port w targets the address of interest with an accepted write.
  // Port 1 beats port 0 when both match. Unused ports must be passed in as 0.
  function automatic rf_pick_t rf_merge_write(input logic [1:0] match);
    rf_pick_t r;
    r.hit = |match;
    r.idx = match[1];
    return r;
  endfunction

endpackage

// File: rtl/register_file_mp_rf_clear_sequencer.sv
// Clear sequencer: walks clrIdx from 0 to DEPTH-1, one entry per cycle,
// after reset or on a clearReq pulse while idle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clearReq      : start a clear when idle (ignored while clearing)
//   busy          : clear in progress
//   clrWe, clrIdx : zero-write strobe and target index for the array
//
// state    | meaning
// ---------+------------------------------------------------
// RF_IDLE  | array usable, writes and reads allowed
// RF_CLEAR | zeroing entry clrIdx this cycle, reads masked
module rf_clear_sequencer
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clearReq,
  output logic              busy,
  output logic              clrWe,
  output logic [ADDR_W-1:0] clrIdx
);

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RF_CLEAR;
      clrIdx <= '0;
    end else begin
      state  <= state_next;
      clrIdx <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = clrIdx;
    case (state)
      RF_IDLE: begin
        if (clearReq) begin
          state_next = RF_CLEAR;
          idx_next   = '0;
        end
      end
      RF_CLEAR: begin
        if (clrIdx == ADDR_W'(DEPTH - 1)) begin
          state_next = RF_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = clrIdx + ADDR_W'(1);
        end
      end
      default: begin
        state_next = RF_CLEAR;
        idx_next   = '0;
      end
    endcase
  end

  assign busy  = (state == RF_CLEAR);
  assign clrWe = busy;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ combinational read ports, NUM_WRITE
// clocked write ports with higher-index-wins merge, optional hardwired zero
// register 0 and a built-in sequential clear.
// Build option: define RF_WRITE_BYPASS_EN to forward same-cycle accepted
// write data to matching reads; otherwise reads see the old array value.
// Ports:
//   clk, rst                               : clock, synchronous active-high reset
//   readEnable/readAddress/readValue       : packed read ports
//   writeEnable/writeAddress/writeData     : packed write ports
//   clearReq                               : start a full-array clear
//   busy                                   : clear in progress (reads 0, writes dropped)
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = RF_DEFAULT_DATA_W,
  parameter int DEPTH     = RF_DEFAULT_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_READ-1:0]           readEnable,
  input  logic [NUM_READ*ADDR_W-1:0]    readAddress,
  output logic [NUM_READ*DATA_W-1:0]    readValue,
  input  logic [NUM_WRITE-1:0]          writeEnable,
  input  logic [NUM_WRITE*ADDR_W-1:0]   writeAddress,
  input  logic [NUM_WRITE*DATA_W-1:0]   writeData,
  input  logic                          clearReq,
  output logic                          busy
);

  logic [DATA_W-1:0]    regs [DEPTH];
  logic                 clrWe;
  logic [ADDR_W-1:0]    clrIdx;
  logic [NUM_WRITE-1:0] wr_acc;
  logic [NUM_WRITE-1:0] wr_win;

  rf_clear_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clearReq (clearReq),
    .busy     (busy),
    .clrWe    (clrWe),
    .clrIdx   (clrIdx)
  );

  // A write is accepted only when idle, not starting a clear, not in reset,
  // and not aimed at a hardwired zero register.
  always_comb begin
    wr_acc = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_acc[w] = writeEnable[w] && !rst && !busy && !clearReq &&
                  !((ZERO_REG != 0) && (writeAddress[w*ADDR_W +: ADDR_W] == '0));
    end
  end

  // A port only commits if it wins the merge against every port hitting its address.
  always_comb begin
    logic [1:0] m;
    rf_pick_t   pick;
    wr_win = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      m = '0;
      for (int v = 0; v < NUM_WRITE; v++) begin
        m[v] = wr_acc[v] &&
               (writeAddress[v*ADDR_W +: ADDR_W] == writeAddress[w*ADDR_W +: ADDR_W]);
      end
      pick      = rf_merge_write(m);
      wr_win[w] = wr_acc[w] && pick.hit && (pick.idx == 1'(w));
    end
  end

  // Array has no parallel reset; the sequencer zeroes it while reads are masked.
  always_ff @(posedge clk) begin
    if (!rst && clrWe) begin
      regs[clrIdx] <= '0;
    end
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_win[w]) begin
        regs[writeAddress[w*ADDR_W +: ADDR_W]] <= writeData[w*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
`ifdef RF_WRITE_BYPASS_EN
    logic [1:0]        m;
    rf_pick_t          pick;
`endif
    readValue = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      ra = readAddress[p*ADDR_W +: ADDR_W];
      rv = regs[ra];
`ifdef RF_WRITE_BYPASS_EN
      m = '0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        m[w] = wr_acc[w] && (writeAddress[w*ADDR_W +: ADDR_W] == ra);
      end
      pick = rf_merge_write(m);
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (pick.hit && (pick.idx == 1'(w))) begin
          rv = writeData[w*DATA_W +: DATA_W];
        end
      end
`endif
      if (!readEnable[p] || busy || ((ZERO_REG != 0) && (ra == '0))) begin
        rv = '0;
      end
      readValue[p*DATA_W +: DATA_W] = rv;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      readEnable;
  logic [NR*AW-1:0]   readAddress;
  logic [NR*DW-1:0]   readValue;
  logic [NW-1:0]      writeEnable;
  logic [NW*AW-1:0]   writeAddress;
  logic [NW*DW-1:0]   writeData;
  logic               clearReq;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain array plus remaining busy cycles.
  logic [DW-1:0] mem [DP];
  int            busy_left   = 0;
  bit            model_valid = 0;

  register_file_mp dut (
    .clk          (clk),
    .rst          (rst),
    .readEnable   (readEnable),
    .readAddress  (readAddress),
    .readValue    (readValue),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .clearReq     (clearReq),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int p);
    int ra;
    logic [DW-1:0] v;
    ra = int'(readAddress[p*AW +: AW]);
    if (!readEnable[p] || busy_left > 0 || ra == 0) return '0;
    v = mem[ra];
`ifdef RF_WRITE_BYPASS_EN
    if (!rst && !clearReq) begin
      for (int w = 0; w < NW; w++) begin
        if (writeEnable[w] && int'(writeAddress[w*AW +: AW]) == ra)
          v = writeData[w*DW +: DW];
      end
    end
`endif
    return v;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < DP; i++) mem[i] = '0;
      busy_left = DP;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (clearReq) begin
      for (int i = 0; i < DP; i++) mem[i] = '0;
      busy_left = DP;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (writeEnable[w] && writeAddress[w*AW +: AW] != '0)
          mem[writeAddress[w*AW +: AW]] = writeData[w*DW +: DW];
      end
    end
  endtask

  // Inputs are set just after negedge; check, take the edge, update model.
  task automatic tick();
    #1;
    if (model_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, busy_left > 0});
      for (int p = 0; p < NR; p++) chk("read", readValue[p*DW +: DW], exp_read(p));
    end
    @(posedge clk);
    model_update();
    model_valid = 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; clearReq = 0; writeEnable = '0; readEnable = '0;
    readAddress = '0; writeAddress = '0; writeData = '0;
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk(tag, n, DP);
  endtask

  task automatic wr(input int port, input int a, input logic [DW-1:0] d);
    writeEnable[port] = 1'b1;
    writeAddress[port*AW +: AW] = AW'(a);
    writeData[port*DW +: DW] = d;
  endtask

  task automatic rd(input int port, input int a);
    readEnable[port] = 1'b1;
    readAddress[port*AW +: AW] = AW'(a);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    count_busy("busy_after_reset");

    for (int a = 0; a < DP; a++) begin
      readEnable = 2'b11; rd(0, a); rd(1, a);
      #1;
      chk("post_reset_p0", readValue[0 +: DW], 32'h0);
      chk("post_reset_p1", readValue[DW +: DW], 32'h0);
      tick();
    end

    idle_inputs(); wr(0, 5, 32'hDEADBEEF); tick();
    idle_inputs(); rd(1, 5); #1; chk("r5_readback", readValue[DW +: DW], 32'hDEADBEEF); tick();

    idle_inputs(); wr(0, 0, 32'h1); tick();
    idle_inputs(); rd(0, 0); #1; chk("r0_zero", readValue[0 +: DW], 32'h0); tick();

    idle_inputs(); wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); tick();
    idle_inputs(); rd(0, 7); #1; chk("collision", readValue[0 +: DW], 32'h22222222); tick();

    idle_inputs(); wr(0, 9, 32'hCAFEF00D); rd(0, 9); #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("bypass_same", readValue[0 +: DW], 32'hCAFEF00D);
`else
    chk("bypass_same", readValue[0 +: DW], 32'h0);
`endif
    tick();
    idle_inputs(); rd(0, 9); #1; chk("bypass_next", readValue[0 +: DW], 32'hCAFEF00D); tick();

    idle_inputs(); rd(1, 5); readEnable[1] = 1'b0; #1;
    chk("read_disabled", readValue[DW +: DW], 32'h0); tick();

    // Fill, clear with writes attempted during busy.
    for (int a = 1; a < DP; a++) begin
      idle_inputs(); wr(0, a, 32'h1000 + 32'(a)); tick();
    end
    idle_inputs(); clearReq = 1; wr(1, 3, 32'h55); tick();
    clearReq = 0;
    begin
      int n = 0;
      while (busy && n < 100) begin
        n++;
        idle_inputs();
        wr(0, $urandom_range(DP-1), $urandom); rd(0, $urandom_range(DP-1));
        clearReq = $urandom_range(1);
        tick();
      end
      chk("busy_after_clear", n, DP);
    end
    for (int a = 0; a < DP; a++) begin
      idle_inputs(); rd(0, a); rd(1, DP-1-a); #1;
      chk("cleared", readValue[0 +: DW] | readValue[DW +: DW], 32'h0);
      tick();
    end

    // Mid-clear reset.
    idle_inputs(); clearReq = 1; tick(); clearReq = 0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1; tick(); rst = 0;
    count_busy("busy_after_midclear_rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(199) == 0);
      clearReq = ($urandom_range(59) == 0);
      readEnable = NR'($urandom);
      writeEnable = NW'($urandom);
      for (int p = 0; p < NR; p++) readAddress[p*AW +: AW] = AW'($urandom_range(7));
      for (int w = 0; w < NW; w++) begin
        writeAddress[w*AW +: AW] = AW'($urandom_range(7));
        writeData[w*DW +: DW] = $urandom;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
